// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester add/subtract arbiter:
// FSM states, op encoding, default datapath width and the round-robin pick.
package alu_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A lone requester always wins; on contention the one not served last wins.
    function automatic logic rr_pick(input logic [1:0] valid, input logic last_id);
        logic pick;
        case (valid)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            default: pick = ~last_id;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/result bundle between two requesters, the arbiter and the result sink.
// slave is the arbiter side, master is the requester/consumer side.
interface alu_arbiter_if #(
    parameter int WIDTH = alu_arbiter_pkg::DEFAULT_WIDTH
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             op0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             op1;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;

    modport slave (
        input  req_valid, a0, b0, op0, a1, b1, op1, res_ready,
        output req_ready, res_valid, res_data, res_id
    );

    modport master (
        output req_valid, a0, b0, op0, a1, b1, op1, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/alu_addsub.sv
// Combinational modulo-2^WIDTH adder/subtractor; subtraction is a + ~b + 1
// so both ops share one carry chain.
module alu_addsub
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] cin;

    always_comb begin
        b_eff = (op == OP_SUB) ? ~b : b;
        cin   = {{(WIDTH-1){1'b0}}, (op == OP_SUB)};
        y     = a + b_eff + cin;
    end
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared add/sub unit.
// IDLE accepts one request, EXEC registers the result, DONE holds it until taken.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    alu_arbiter_if.slave bus,
    output logic         busy
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             op_q, op_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;

    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] alu_y;

    // The ALU only ever sees the captured operands, so one instance serves both.
    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    always_comb begin
        grant_id = rr_pick(bus.req_valid, last_q);
        accept   = (state_q == ST_IDLE) && (bus.req_valid != 2'b00);
        bus.req_ready = 2'b00;
        if (accept) bus.req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        last_d      = last_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                    a_d     = grant_id ? bus.a1  : bus.a0;
                    b_d     = grant_id ? bus.b1  : bus.b0;
                    op_d    = grant_id ? bus.op1 : bus.op0;
                    id_d    = grant_id;
                    last_d  = grant_id;
                end
            end
            ST_EXEC: begin
                state_d     = ST_DONE;
                res_data_d  = alu_y;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Reset leaves the pointer on requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            last_q      <= last_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_valid = res_valid_q;
    assign busy          = busy_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 3, operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept strobe; at most one bit high per cycle.
REQ-006 a0, b0  input  WIDTH each  requester 0 operands.
REQ-007 op0  input  1  requester 0 operation: 0 = A+B, 1 = A-B.
REQ-008 a1, b1  input  WIDTH each  requester 1 operands.
REQ-009 op1  input  1  requester 1 operation, same encoding as op0.
REQ-010 res_valid  output  1  result valid.
REQ-011 res_ready  input  1  result consumer ready.
REQ-012 res_data  output  WIDTH  registered result.
REQ-013 res_id  output  1  index of the requester that owns res_data.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States: IDLE, EXEC, DONE; one-hot or binary encoding is implementer's choice.
REQ-016 IDLE: if any req_valid is high, grant one requester; req_ready[grant] is high combinationally in that cycle; the clock edge captures a, b, op and the grant ID, and the state moves to EXEC.
REQ-017 req_ready is 0 in EXEC and DONE, and 0 in IDLE when req_valid is 0.
REQ-018 Arbitration: single valid requester always wins; if both are valid, the requester not granted last wins (round-robin); the pointer updates on each accept.
REQ-019 EXEC: the registered ALU result (op 0: a+b; op 1: a+~b+1) is written to res_data; state moves to DONE after one cycle.
REQ-020 Arithmetic is modulo 2^WIDTH; carry and borrow are discarded (WIDTH=3: 7+1=0, 0-1=7).
REQ-021 DONE: res_valid=1; res_data and res_id hold stable until res_ready=1 is sampled; that edge returns to IDLE.
REQ-022 Latency: accept edge N produces res_valid=1 after edge N+1; minimum issue interval is 3 cycles.
REQ-023 A requester holds req_valid and its operands stable until it sees req_ready; the block samples operands only on the accept edge.
REQ-024 res_ready asserted outside DONE has no effect.

Reset
REQ-025 reset_n low asynchronously forces state IDLE, res_valid=0, res_data=0, res_id=0, busy=0, and round-robin priority to requester 0.
REQ-026 Reset asserted mid-operation (EXEC or DONE) discards the in-flight result; no res_valid is produced for it.
REQ-027 After reset release, the first accept occurs no earlier than the first rising edge with reset_n high.

Structure
REQ-028 A shared package holds the state enumeration, the op encoding constants (OP_ADD=0, OP_SUB=1) and the default WIDTH.
REQ-029 The adder/subtractor is one combinational sub-module, alu_addsub (inputs a, b, op; output y), instantiated once and shared by both requesters.
REQ-030 The arbiter FSM, operand registers and result register stay in alu_arbiter.

Verification
REQ-031 Reset, then req_valid=01, a0=3, b0=2, op0=0 -> req_ready=01 in the same cycle; res_valid=1, res_data=5, res_id=0 after two edges.
REQ-032 req_valid=10, a1=0, b1=1, op1=1 -> res_data=7, res_id=1; then a1=7, b1=1, op1=0 -> res_data=0.
REQ-033 Hold req_valid=11 over four transactions with res_ready=1 -> grants alternate 0,1,0,1, each result tagged with the matching res_id.
REQ-034 res_ready=0 for 5 cycles in DONE with a new req_valid pending -> res_data and res_id stable, req_ready=00, busy=1; res_ready=1 -> IDLE, then the pending request is accepted.
REQ-035 Assert reset_n=0 during EXEC -> outputs immediately 0; no res_valid after release; next grant with req_valid=11 goes to requester 0.
